pkt_tcp_crc_arb: RTL and testbench

Packet-granularity round-robin arbiter that shares one TCP-checksum insertion unit between several 134-bit packet sources, such as the DMA TX path and the CPU TX path. It sits directly in front of the checksum unit. It forwards one whole packet at a time, contiguously. It enforces an idle gap after each tail so the unit's checksum FSM can return to idle. It also tracks a word credit, so the unit's internal packet FIFO never overflows.

---
 rtl/pkt_tcp_crc_arb.sv | 182 ++++++++++++++++++
 tb/tb_pkt_tcp_crc_arb.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pkt_tcp_crc_arb.sv
// Packet-granularity round-robin arbiter in front of a shared TCP checksum unit.
// Forwards whole packets, enforces a post-tail idle gap and tracks FIFO word credit.
`timescale 1ns/1ps
module pkt_tcp_crc_arb #(
    parameter int unsigned NUM_PORTS     = 2,
    parameter int unsigned GAP_CYCLES    = 8,
    parameter int unsigned FIFO_WORDS    = 128,
    parameter int unsigned MAX_PKT_WORDS = 96,
    localparam int unsigned GW = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
    input  logic                   i_clk,
    input  logic                   i_rst_n,
    input  logic [NUM_PORTS-1:0]   i_pkt_avail,
    input  logic [NUM_PORTS-1:0]   i_data_valid,
    input  logic [NUM_PORTS*134-1:0] i_data,
    output logic [NUM_PORTS-1:0]   o_data_ready,
    output logic                   o_data_valid,
    output logic [133:0]           o_data,
    input  logic                   i_ret_valid,
    output logic [GW-1:0]          o_grant,
    output logic                   o_busy,
    output logic                   o_proto_err
);

    localparam int unsigned WW  = 134;
    localparam int unsigned CW  = $clog2(FIFO_WORDS + 1);
    localparam int unsigned WCW = $clog2(MAX_PKT_WORDS + 2);
    localparam int unsigned GCW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [1:0]  TAG_HEAD = 2'b01;
    localparam logic [1:0]  TAG_TAIL = 2'b10;

    typedef struct packed {
        logic [1:0]   tag;
        logic [3:0]   be;
        logic [127:0] payload;
    } word_t;

    typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

    state_t           state_q, state_d;
    logic [GW-1:0]    grant_q, grant_d, rr_q, rr_d;
    logic [CW-1:0]    credit_q, credit_d;
    logic [WCW-1:0]   wcnt_q, wcnt_d;
    logic [GCW-1:0]   gap_q, gap_d;
    logic             in_pkt_q, in_pkt_d;
    logic             len_err_q, len_err_d;
    logic [WW-1:0]    data_q, data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;
    logic             fwd, found;
    int unsigned      idx;
    word_t            word;

    // Ready is a pure decode of registered state so sources never see a comb loop.
    assign o_data_ready = (state_q == SEND) ? (NUM_PORTS'(1) << grant_q) : '0;
    assign o_data_valid = valid_q;
    assign o_data       = data_q;
    assign o_grant      = grant_q;
    assign o_busy       = busy_q;
    assign o_proto_err  = err_q;

    always_comb begin
        state_d   = state_q;
        grant_d   = grant_q;
        rr_d      = rr_q;
        credit_d  = credit_q;
        wcnt_d    = wcnt_q;
        gap_d     = gap_q;
        in_pkt_d  = in_pkt_q;
        len_err_d = len_err_q;
        data_d    = data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        fwd       = 1'b0;
        found     = 1'b0;
        idx       = 0;
        word      = i_data[32'(grant_q)*WW +: WW];

        case (state_q)
            IDLE: begin
                if (credit_q >= CW'(MAX_PKT_WORDS)) begin
                    for (int unsigned i = 0; i < NUM_PORTS; i++) begin
                        idx = (32'(rr_q) + i) % NUM_PORTS;
                        if (!found && i_pkt_avail[idx]) begin
                            found   = 1'b1;
                            grant_d = GW'(idx);
                            rr_d    = GW'((idx + 1) % NUM_PORTS);
                        end
                    end
                end
                if (found) begin
                    state_d   = SEND;
                    wcnt_d    = '0;
                    in_pkt_d  = 1'b0;
                    len_err_d = 1'b0;
                end
            end
            SEND: begin
                if (i_data_valid[grant_q]) begin
                    if (!in_pkt_q) begin
                        // Anything but a head opening a grant is dropped.
                        if (word.tag == TAG_HEAD) begin
                            fwd      = 1'b1;
                            in_pkt_d = 1'b1;
                            wcnt_d   = WCW'(1);
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        fwd = 1'b1;
                        if (wcnt_q != '1) wcnt_d = wcnt_q + WCW'(1);
                        if (word.tag == TAG_HEAD) err_d = 1'b1;
                        if ((wcnt_q >= WCW'(MAX_PKT_WORDS)) && !len_err_q) begin
                            err_d     = 1'b1;
                            len_err_d = 1'b1;
                        end
                        if (word.tag == TAG_TAIL) begin
                            state_d = GAP;
                            gap_d   = '0;
                        end
                    end
                end else if (in_pkt_q) begin
                    err_d = 1'b1;
                end
            end
            GAP: begin
                if (gap_q == GCW'(GAP_CYCLES - 1)) state_d = IDLE;
                else                               gap_d   = gap_q + GCW'(1);
            end
            default: state_d = IDLE;
        endcase

        // Credit: forwarded word consumes, returned word refunds, both cancel.
        case ({fwd, i_ret_valid})
            2'b10: begin
                if (credit_q == '0) err_d = 1'b1;
                else                credit_d = credit_q - CW'(1);
            end
            2'b01: begin
                if (credit_q == CW'(FIFO_WORDS)) err_d = 1'b1;
                else                             credit_d = credit_q + CW'(1);
            end
            default: ;
        endcase

        valid_d = fwd;
        if (fwd) data_d = word;
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q   <= IDLE;
            grant_q   <= '0;
            rr_q      <= '0;
            credit_q  <= CW'(FIFO_WORDS);
            wcnt_q    <= '0;
            gap_q     <= '0;
            in_pkt_q  <= 1'b0;
            len_err_q <= 1'b0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            grant_q   <= grant_d;
            rr_q      <= rr_d;
            credit_q  <= credit_d;
            wcnt_q    <= wcnt_d;
            gap_q     <= gap_d;
            in_pkt_q  <= in_pkt_d;
            len_err_q <= len_err_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            busy_q    <= busy_d;
        end
    end

endmodule

// File: tb/tb_pkt_tcp_crc_arb.sv
// Directed + randomized bench for pkt_tcp_crc_arb with queue-based source and output model.
`timescale 1ns/1ps
module tb_pkt_tcp_crc_arb;

    localparam int unsigned NP = 2;
    localparam int unsigned G  = 8;
    localparam int unsigned FW = 128;
    localparam int unsigned MX = 96;
    localparam int unsigned W  = 134;

    logic            i_clk = 1'b0;
    logic            i_rst_n = 1'b0;
    logic [NP-1:0]   i_pkt_avail = '0;
    logic [NP-1:0]   i_data_valid = '0;
    logic [NP*W-1:0] i_data = '0;
    logic [NP-1:0]   o_data_ready;
    logic            o_data_valid;
    logic [W-1:0]    o_data;
    logic            i_ret_valid = 1'b0;
    logic [0:0]      o_grant;
    logic            o_busy;
    logic            o_proto_err;

    pkt_tcp_crc_arb #(.NUM_PORTS(NP), .GAP_CYCLES(G), .FIFO_WORDS(FW), .MAX_PKT_WORDS(MX)) dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_pkt_avail(i_pkt_avail),
        .i_data_valid(i_data_valid), .i_data(i_data), .o_data_ready(o_data_ready),
        .o_data_valid(o_data_valid), .o_data(o_data), .i_ret_valid(i_ret_valid),
        .o_grant(o_grant), .o_busy(o_busy), .o_proto_err(o_proto_err)
    );

    always #5 i_clk = ~i_clk;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int rdy_bad = 0;
    bit ret_echo = 1'b0;

    logic [W-1:0] src_q [NP][$];
    logic [W-1:0] exp_q [NP][$];
    logic [W-1:0] out_w [$];
    int           out_g [$];
    int           out_c [$];
    int           err_c [$];

    always @(posedge i_clk) cyc <= cyc + 1;

    // Output monitor: records forwarded words, error pulses and foreign-ready events.
    always @(negedge i_clk) begin
        if (i_rst_n) begin
            if (o_data_valid) begin
                out_w.push_back(o_data);
                out_g.push_back(int'(o_grant));
                out_c.push_back(cyc);
            end
            if (o_proto_err) err_c.push_back(cyc);
            if ((o_data_ready & ~(NP'(1) << o_grant)) != '0) rdy_bad++;
        end
    end

    task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        tests++;
        assert (obs === expv) else begin
            fails++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    function automatic logic [W-1:0] mk_word(input logic [1:0] tag);
        return {tag, 4'($urandom), $urandom, $urandom, $urandom, $urandom};
    endfunction

    task automatic add_pkt(input int p, input int n, input bit bad_first);
        logic [W-1:0] w;
        if (bad_first) src_q[p].push_back(mk_word(2'b11));
        for (int k = 0; k < n; k++) begin
            w = mk_word((k == 0) ? 2'b01 : (k == n - 1) ? 2'b10 : 2'b11);
            src_q[p].push_back(w);
            exp_q[p].push_back(w);
        end
    endtask

    function automatic bit any_pending();
        bit a = 1'b0;
        for (int p = 0; p < NP; p++) if (src_q[p].size() > 0) a = 1'b1;
        return a;
    endfunction

    // One clock of the source model: present head-of-queue word, pop on handshake.
    task automatic cycle();
        logic [NP-1:0] r, v;
        for (int p = 0; p < NP; p++) begin
            v[p] = (src_q[p].size() > 0);
            i_pkt_avail[p]  = v[p];
            i_data_valid[p] = v[p];
            i_data[p*W +: W] = v[p] ? src_q[p][0] : '0;
        end
        r = o_data_ready;
        @(posedge i_clk);
        #1;
        if (ret_echo) i_ret_valid = o_data_valid;
        for (int p = 0; p < NP; p++) if (r[p] && v[p]) void'(src_q[p].pop_front());
    endtask

    task automatic run_until_empty(input string tag, input int budget);
        int n = 0;
        while (any_pending() && n < budget) begin
            cycle();
            n++;
        end
        chk({tag, "_timeout"}, W'(any_pending()), '0);
        repeat (G + 4) cycle();
    endtask

    task automatic do_reset();
        i_rst_n = 1'b0;
        ret_echo = 1'b0;
        i_ret_valid = 1'b0;
        for (int p = 0; p < NP; p++) begin
            src_q[p].delete();
            exp_q[p].delete();
        end
        repeat (2) cycle();
        i_rst_n = 1'b1;
        out_w.delete();
        out_g.delete();
        out_c.delete();
        err_c.delete();
        rdy_bad = 0;
    endtask

    // Each output word, grouped by the grant it appeared under, must match that port's packets.
    task automatic check_stream(input string tag);
        int ix [NP];
        int total = 0;
        int g;
        for (int p = 0; p < NP; p++) begin
            ix[p] = 0;
            total += exp_q[p].size();
        end
        chk({tag, "_count"}, W'(out_w.size()), W'(total));
        for (int i = 0; i < out_w.size(); i++) begin
            g = out_g[i];
            if (ix[g] < exp_q[g].size())
                chk($sformatf("%s_w%0d", tag, i), out_w[i], exp_q[g][ix[g]]);
            ix[g]++;
        end
    endtask

    initial begin
        int k0, heads, n;

        // Reset state
        do_reset();
        chk("rst_valid", W'(o_data_valid), '0);
        chk("rst_data", o_data, '0);
        chk("rst_ready", W'(o_data_ready), '0);
        chk("rst_grant", W'(o_grant), '0);
        chk("rst_busy", W'(o_busy), '0);
        chk("rst_err", W'(o_proto_err), '0);
        chk("rst_credit", W'(dut.credit_q), W'(FW));

        // Single 4-word packet on port 0
        add_pkt(0, 4, 0);
        k0 = cyc;
        cycle();
        chk("t1_ready", W'(o_data_ready), W'(2'b01));
        chk("t1_grant", W'(o_grant), '0);
        chk("t1_busy", W'(o_busy), W'(1));
        run_until_empty("t1", 50);
        check_stream("t1");
        for (int i = 0; i < 4; i++)
            chk($sformatf("t1_cyc%0d", i), W'(out_c.size() > i ? out_c[i] : -1), W'(k0 + 2 + i));
        chk("t1_credit_low", W'(dut.credit_q), W'(FW - 4));
        chk("t1_noerr", W'(err_c.size()), '0);
        i_ret_valid = 1'b1;
        repeat (4) cycle();
        i_ret_valid = 1'b0;
        cycle();
        chk("t1_credit_back", W'(dut.credit_q), W'(FW));
        i_ret_valid = 1'b1;
        cycle();
        i_ret_valid = 1'b0;
        cycle();
        chk("t1_sat_err", W'(err_c.size()), W'(1));
        chk("t1_sat_credit", W'(dut.credit_q), W'(FW));

        // Two ports continuously available: alternation and gap timing
        do_reset();
        for (int r = 0; r < 2; r++) begin
            add_pkt(0, 3, 0);
            add_pkt(1, 3, 0);
        end
        run_until_empty("t2", 200);
        check_stream("t2");
        heads = 0;
        for (int i = 0; i < out_w.size(); i++) begin
            if (out_w[i][133:132] == 2'b01) begin
                chk($sformatf("t2_grant%0d", heads), W'(out_g[i]), W'(heads % 2));
                heads++;
            end
            if (out_w[i][133:132] == 2'b10 && i + 1 < out_w.size())
                chk($sformatf("t2_gap%0d", i), W'(out_c[i+1] - out_c[i]), W'(G + 2));
        end
        chk("t2_heads", W'(heads), W'(4));
        chk("t2_rdy_excl", W'(rdy_bad), '0);
        chk("t2_noerr", W'(err_c.size()), '0);

        // Credit starvation and release at exactly MAX_PKT_WORDS
        do_reset();
        add_pkt(0, 38, 0);
        run_until_empty("t3a", 100);
        chk("t3_credit90", W'(dut.credit_q), W'(FW - 38));
        add_pkt(0, 3, 0);
        repeat (20) cycle();
        chk("t3_starve_busy", W'(o_busy), '0);
        chk("t3_starve_out", W'(out_w.size()), W'(38));
        i_ret_valid = 1'b1;
        repeat (6) cycle();
        i_ret_valid = 1'b0;
        chk("t3_credit96", W'(dut.credit_q), W'(MX));
        chk("t3_not_yet", W'(o_data_ready), '0);
        cycle();
        chk("t3_grant_now", W'(o_data_ready), W'(2'b01));
        run_until_empty("t3b", 50);
        check_stream("t3");
        chk("t3_credit_end", W'(dut.credit_q), W'(MX - 3));

        // Body word first: dropped with one error pulse
        do_reset();
        add_pkt(0, 3, 1);
        run_until_empty("t4", 50);
        check_stream("t4");
        chk("t4_err", W'(err_c.size()), W'(1));
        chk("t4_credit", W'(dut.credit_q), W'(FW - 3));

        // Oversize 100-word packet
        do_reset();
        add_pkt(0, 100, 0);
        run_until_empty("t5", 200);
        check_stream("t5");
        chk("t5_err", W'(err_c.size()), W'(1));
        chk("t5_err_at97", W'(err_c.size() > 0 && out_c.size() > 96 ? err_c[0] - out_c[96] : -1), '0);
        chk("t5_credit", W'(dut.credit_q), W'(FW - 100));

        // Asynchronous reset mid-packet
        do_reset();
        add_pkt(1, 10, 0);
        n = 0;
        while (out_w.size() < 4 && n < 50) begin
            cycle();
            n++;
        end
        chk("t6_midpkt", W'(out_w.size() >= 4), W'(1));
        chk("t6_grant_pre", W'(o_grant), W'(1));
        i_rst_n = 1'b0;
        #1;
        chk("t6_valid", W'(o_data_valid), '0);
        chk("t6_data", o_data, '0);
        chk("t6_ready", W'(o_data_ready), '0);
        chk("t6_grant", W'(o_grant), '0);
        chk("t6_busy", W'(o_busy), '0);
        chk("t6_err", W'(o_proto_err), '0);
        do_reset();
        chk("t6_credit", W'(dut.credit_q), W'(FW));
        add_pkt(1, 3, 0);
        add_pkt(0, 3, 0);
        run_until_empty("t6", 100);
        chk("t6_first_grant", W'(out_g.size() > 0 ? out_g[0] : -1), '0);
        check_stream("t6");

        // Randomized packets with checksum-unit credit echo
        do_reset();
        ret_echo = 1'b1;
        repeat (8) add_pkt(int'($urandom_range(0, NP - 1)), int'($urandom_range(2, 12)), 0);
        run_until_empty("t7", 800);
        check_stream("t7");
        chk("t7_noerr", W'(err_c.size()), '0);
        chk("t7_credit", W'(dut.credit_q), W'(FW));
        chk("t7_rdy_excl", W'(rdy_bad), '0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
